// File: rtl/types_pkg.sv
// Shared types for the functional-unit status scoreboard: row layout, producer tags
// and default sizing.
package types_pkg;

  localparam int unsigned NUM_FU_DEF = 3;
  localparam int unsigned REG_W_DEF  = 5;
  localparam int unsigned TAG_W_DEF  = $clog2(NUM_FU_DEF + 1);
  localparam int unsigned FU_W_DEF   = $clog2(NUM_FU_DEF);

  typedef logic [REG_W_DEF-1:0] reg_idx_t;
  typedef logic [TAG_W_DEF-1:0] tag_t;

  typedef struct packed {
    logic     busy;
    logic     issued;
    reg_idx_t r;
    reg_idx_t r1;
    reg_idx_t r2;
    tag_t     t1;
    tag_t     t2;
  } fust_row_t;

  // Tag 0 means "no producer", so FU k is tagged k+1.
  function automatic tag_t fu_to_tag(input logic [FU_W_DEF-1:0] fu);
    return tag_t'(fu) + tag_t'(1);
  endfunction

endpackage

// File: rtl/fust_rs_table.sv
// Result-status table: one producer tag per architectural register, with a
// set port, an owner-conditional clear port and three registered-state lookups.
module fust_rs_table
  import types_pkg::*;
#(
  parameter int unsigned REG_W = REG_W_DEF,
  parameter int unsigned TAG_W = TAG_W_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             flush,
  input  logic             set_en_i,
  input  logic [REG_W-1:0] set_idx_i,
  input  logic [TAG_W-1:0] set_tag_i,
  input  logic             clr_en_i,
  input  logic [REG_W-1:0] clr_idx_i,
  input  logic [TAG_W-1:0] clr_tag_i,
  input  logic [REG_W-1:0] rd_idx_i,
  input  logic [REG_W-1:0] rs1_idx_i,
  input  logic [REG_W-1:0] rs2_idx_i,
  output logic [TAG_W-1:0] rd_tag_o,
  output logic [TAG_W-1:0] rs1_tag_o,
  output logic [TAG_W-1:0] rs2_tag_o
);

  localparam int unsigned NUM_REG = 1 << REG_W;

  logic [TAG_W-1:0] rs_q [NUM_REG];
  logic [TAG_W-1:0] rs_d [NUM_REG];

  // Register 0 is hardwired to "no producer"; it is never written.
  always_comb begin
    rs_d = rs_q;
    if (clr_en_i && (clr_idx_i != '0) && (rs_q[clr_idx_i] == clr_tag_i)) begin
      rs_d[clr_idx_i] = '0;
    end
    if (set_en_i && (set_idx_i != '0)) begin
      rs_d[set_idx_i] = set_tag_i;
    end
    if (flush) begin
      for (int unsigned k = 0; k < NUM_REG; k++) begin
        rs_d[k] = '0;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned k = 0; k < NUM_REG; k++) begin
        rs_q[k] <= '0;
      end
    end else begin
      rs_q <= rs_d;
    end
  end

  assign rd_tag_o  = (rd_idx_i  == '0) ? '0 : rs_q[rd_idx_i];
  assign rs1_tag_o = (rs1_idx_i == '0) ? '0 : rs_q[rs1_idx_i];
  assign rs2_tag_o = (rs2_idx_i == '0) ? '0 : rs_q[rs2_idx_i];

endmodule

// File: rtl/fust_scoreboard.sv
// Scoreboard tracking functional-unit status rows and register producers;
// arbitrates dispatch (structural/WAW), issue (RAW) and writeback (WAR).
module fust_scoreboard
  import types_pkg::*;
#(
  parameter  int unsigned NUM_FU = NUM_FU_DEF,
  parameter  int unsigned REG_W  = REG_W_DEF,
  localparam int unsigned TAG_W  = $clog2(NUM_FU + 1),
  localparam int unsigned FU_W   = $clog2(NUM_FU)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              flush,
  input  logic              disp_valid,
  input  logic [FU_W-1:0]   disp_fu,
  input  logic [REG_W-1:0]  disp_rd,
  input  logic [REG_W-1:0]  disp_rs1,
  input  logic [REG_W-1:0]  disp_rs2,
  output logic              disp_ready,
  output logic [NUM_FU-1:0] issue_rdy,
  input  logic [NUM_FU-1:0] issue_grant,
  input  logic              wb_valid,
  input  logic [FU_W-1:0]   wb_fu,
  output logic              wb_ready,
  output logic [NUM_FU-1:0] busy_o
);

  fust_row_t rows_q [NUM_FU];
  fust_row_t rows_d [NUM_FU];

  logic [TAG_W-1:0] rd_tag;
  logic [TAG_W-1:0] rs1_tag;
  logic [TAG_W-1:0] rs2_tag;
  logic [TAG_W-1:0] disp_tag;
  logic [TAG_W-1:0] wb_tag;
  logic [TAG_W-1:0] disp_t1;
  logic [TAG_W-1:0] disp_t2;
  logic [REG_W-1:0] wb_rd;
  logic             disp_fu_ok;
  logic             disp_row_busy;
  logic             disp_fire;
  logic             wb_fu_ok;
  logic             wb_row_busy;
  logic             wb_row_issued;
  logic             war_stall;
  logic             wb_fire;

  fust_rs_table #(
    .REG_W (REG_W),
    .TAG_W (TAG_W)
  ) u_rs_table (
    .CLK       (CLK),
    .RST       (RST),
    .flush     (flush),
    .set_en_i  (disp_fire),
    .set_idx_i (disp_rd),
    .set_tag_i (disp_tag),
    .clr_en_i  (wb_fire),
    .clr_idx_i (wb_rd),
    .clr_tag_i (wb_tag),
    .rd_idx_i  (disp_rd),
    .rs1_idx_i (disp_rs1),
    .rs2_idx_i (disp_rs2),
    .rd_tag_o  (rd_tag),
    .rs1_tag_o (rs1_tag),
    .rs2_tag_o (rs2_tag)
  );

  assign disp_tag = fu_to_tag(disp_fu);
  assign wb_tag   = fu_to_tag(wb_fu);

  // Decode of the dispatch and writeback target rows; unknown FU indices are never ready.
  always_comb begin
    disp_fu_ok    = 1'b0;
    disp_row_busy = 1'b1;
    wb_fu_ok      = 1'b0;
    wb_row_busy   = 1'b0;
    wb_row_issued = 1'b0;
    wb_rd         = '0;
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      if (disp_fu == FU_W'(i)) begin
        disp_fu_ok    = 1'b1;
        disp_row_busy = rows_q[i].busy;
      end
      if (wb_fu == FU_W'(i)) begin
        wb_fu_ok      = 1'b1;
        wb_row_busy   = rows_q[i].busy;
        wb_row_issued = rows_q[i].issued;
        wb_rd         = rows_q[i].r;
      end
    end
  end

  // A waiting row that has already captured the old value of wb_rd must read it first.
  always_comb begin
    war_stall = 1'b0;
    if (wb_rd != '0) begin
      for (int unsigned j = 0; j < NUM_FU; j++) begin
        if ((wb_fu != FU_W'(j)) && rows_q[j].busy && !rows_q[j].issued &&
            (((rows_q[j].r1 == wb_rd) && (rows_q[j].t1 == '0)) ||
             ((rows_q[j].r2 == wb_rd) && (rows_q[j].t2 == '0)))) begin
          war_stall = 1'b1;
        end
      end
    end
  end

  always_comb begin
    issue_rdy = '0;
    busy_o    = '0;
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      issue_rdy[i] = rows_q[i].busy && !rows_q[i].issued &&
                     (rows_q[i].t1 == '0) && (rows_q[i].t2 == '0);
      busy_o[i]    = rows_q[i].busy;
    end
  end

  assign disp_ready = disp_fu_ok && !disp_row_busy && ((disp_rd == '0) || (rd_tag == '0));
  assign wb_ready   = !war_stall && wb_fu_ok && wb_row_busy && wb_row_issued;
  assign disp_fire  = disp_valid && disp_ready;
  assign wb_fire    = wb_valid && wb_ready;

  // Operand tags produced by the unit retiring this cycle are bypassed to zero.
  assign disp_t1 = (wb_fire && (rs1_tag == wb_tag)) ? '0 : rs1_tag;
  assign disp_t2 = (wb_fire && (rs2_tag == wb_tag)) ? '0 : rs2_tag;

  always_comb begin
    rows_d = rows_q;
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      if (issue_grant[i] && issue_rdy[i]) begin
        rows_d[i].issued = 1'b1;
      end
      if (wb_fire) begin
        if (rows_d[i].t1 == wb_tag) begin
          rows_d[i].t1 = '0;
        end
        if (rows_d[i].t2 == wb_tag) begin
          rows_d[i].t2 = '0;
        end
        if (wb_fu == FU_W'(i)) begin
          rows_d[i].busy   = 1'b0;
          rows_d[i].issued = 1'b0;
        end
      end
      if (disp_fire && (disp_fu == FU_W'(i))) begin
        rows_d[i].busy   = 1'b1;
        rows_d[i].issued = 1'b0;
        rows_d[i].r      = disp_rd;
        rows_d[i].r1     = disp_rs1;
        rows_d[i].r2     = disp_rs2;
        rows_d[i].t1     = disp_t1;
        rows_d[i].t2     = disp_t2;
      end
      if (flush) begin
        rows_d[i] = '0;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned i = 0; i < NUM_FU; i++) begin
        rows_q[i] <= '0;
      end
    end else begin
      rows_q <= rows_d;
    end
  end

endmodule

// File: tb/tb_fust_scoreboard.sv
// Self-checking bench: directed hazard scenarios plus random traffic, all
// compared against a behavioural scoreboard model.
module tb_fust_scoreboard;

  localparam int NFU  = 3;
  localparam int NREG = 32;

  logic       CLK = 1'b0;
  logic       RST;
  logic       flush;
  logic       disp_valid;
  logic [1:0] disp_fu;
  logic [4:0] disp_rd;
  logic [4:0] disp_rs1;
  logic [4:0] disp_rs2;
  logic       disp_ready;
  logic [2:0] issue_rdy;
  logic [2:0] issue_grant;
  logic       wb_valid;
  logic [1:0] wb_fu;
  logic       wb_ready;
  logic [2:0] busy_o;

  int    n_chk;
  int    n_bad;
  string phase;

  int m_busy [NFU];
  int m_iss  [NFU];
  int m_r    [NFU];
  int m_r1   [NFU];
  int m_r2   [NFU];
  int m_t1   [NFU];
  int m_t2   [NFU];
  int m_rs   [NREG];

  fust_scoreboard dut (
    .CLK         (CLK),
    .RST         (RST),
    .flush       (flush),
    .disp_valid  (disp_valid),
    .disp_fu     (disp_fu),
    .disp_rd     (disp_rd),
    .disp_rs1    (disp_rs1),
    .disp_rs2    (disp_rs2),
    .disp_ready  (disp_ready),
    .issue_rdy   (issue_rdy),
    .issue_grant (issue_grant),
    .wb_valid    (wb_valid),
    .wb_fu       (wb_fu),
    .wb_ready    (wb_ready),
    .busy_o      (busy_o)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
    n_chk++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s/%s: got %0d want %0d at %0t", phase, tag, obs, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  task automatic model_reset();
    for (int i = 0; i < NFU; i++) begin
      m_busy[i] = 0; m_iss[i] = 0; m_r[i] = 0; m_r1[i] = 0; m_r2[i] = 0; m_t1[i] = 0; m_t2[i] = 0;
    end
    for (int k = 0; k < NREG; k++) m_rs[k] = 0;
  endtask

  function automatic int exp_issue(input int i);
    return (m_busy[i] != 0 && m_iss[i] == 0 && m_t1[i] == 0 && m_t2[i] == 0) ? 1 : 0;
  endfunction

  function automatic int exp_issue_vec();
    int v = 0;
    for (int i = 0; i < NFU; i++) v |= exp_issue(i) << i;
    return v;
  endfunction

  function automatic int exp_busy_vec();
    int v = 0;
    for (int i = 0; i < NFU; i++) v |= (m_busy[i] != 0 ? 1 : 0) << i;
    return v;
  endfunction

  function automatic int exp_disp_ready();
    int f = int'(disp_fu);
    int rd = int'(disp_rd);
    if (f >= NFU) return 0;
    if (m_busy[f] != 0) return 0;
    return (rd == 0 || m_rs[rd] == 0) ? 1 : 0;
  endfunction

  function automatic int exp_wb_ready();
    int f = int'(wb_fu);
    int rr;
    if (f >= NFU) return 0;
    rr = m_r[f];
    if (rr != 0) begin
      for (int j = 0; j < NFU; j++) begin
        if (j != f && m_busy[j] != 0 && m_iss[j] == 0 &&
            ((m_r1[j] == rr && m_t1[j] == 0) || (m_r2[j] == rr && m_t2[j] == 0)))
          return 0;
      end
    end
    return (m_busy[f] != 0 && m_iss[f] != 0) ? 1 : 0;
  endfunction

  task automatic model_update();
    int dr, wr, wtag, t1n, t2n, rr, f;
    int ir [NFU];
    dr = exp_disp_ready();
    wr = exp_wb_ready();
    for (int i = 0; i < NFU; i++) ir[i] = exp_issue(i);
    if (flush) begin
      model_reset();
      return;
    end
    wtag = int'(wb_fu) + 1;
    t1n  = m_rs[int'(disp_rs1)];
    t2n  = m_rs[int'(disp_rs2)];
    if (wb_valid && wr != 0) begin
      if (t1n == wtag) t1n = 0;
      if (t2n == wtag) t2n = 0;
    end
    for (int i = 0; i < NFU; i++)
      if (issue_grant[i] && ir[i] != 0) m_iss[i] = 1;
    if (wb_valid && wr != 0) begin
      f  = int'(wb_fu);
      rr = m_r[f];
      if (rr != 0 && m_rs[rr] == wtag) m_rs[rr] = 0;
      m_busy[f] = 0;
      m_iss[f]  = 0;
      for (int i = 0; i < NFU; i++) begin
        if (m_t1[i] == wtag) m_t1[i] = 0;
        if (m_t2[i] == wtag) m_t2[i] = 0;
      end
    end
    if (disp_valid && dr != 0) begin
      f = int'(disp_fu);
      m_busy[f] = 1; m_iss[f] = 0;
      m_r[f] = int'(disp_rd); m_r1[f] = int'(disp_rs1); m_r2[f] = int'(disp_rs2);
      m_t1[f] = t1n; m_t2[f] = t2n;
      if (disp_rd != 0) m_rs[int'(disp_rd)] = f + 1;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic check_outputs();
    check_eq("disp_ready", int'(disp_ready), exp_disp_ready());
    check_eq("issue_rdy",  int'(issue_rdy),  exp_issue_vec());
    check_eq("wb_ready",   int'(wb_ready),   exp_wb_ready());
    check_eq("busy_o",     int'(busy_o),     exp_busy_vec());
  endtask

  task automatic set_in(input bit dv, input int fu, input int rd, input int rs1, input int rs2,
                        input int gr, input bit wv, input int wfu, input bit fl);
    disp_valid  = dv;
    disp_fu     = 2'(fu);
    disp_rd     = 5'(rd);
    disp_rs1    = 5'(rs1);
    disp_rs2    = 5'(rs2);
    issue_grant = 3'(gr);
    wb_valid    = wv;
    wb_fu       = 2'(wfu);
    flush       = fl;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Called at a falling edge with inputs applied; leaves at the next falling edge.
  task automatic step();
    #1;
    check_outputs();
    model_update();
    @(negedge CLK);
  endtask

  initial begin
    n_chk = 0;
    n_bad = 0;
    phase = "reset";
    RST = 1'b1;
    idle();
    model_reset();
    #3;
    check_outputs();
    @(negedge CLK);
    RST = 1'b0;

    // RAW: FU1 waits on FU0's rd=3 until FU0 writes back.
    phase = "raw";
    set_in(1, 0, 3, 0, 0, 0, 0, 0, 0); step();
    set_in(1, 1, 4, 3, 0, 1, 0, 0, 0); step();
    check_eq("raw_wait", int'(issue_rdy[1]), 0);
    set_in(0, 0, 0, 0, 0, 0, 1, 0, 0); step();
    check_eq("raw_woken", int'(issue_rdy[1]), 1);
    set_in(0, 0, 0, 0, 0, 2, 0, 0, 0); step();
    set_in(0, 0, 0, 0, 0, 0, 1, 1, 0); step();

    // WAW: a second writer of r5 stalls until FU0 retires.
    phase = "waw";
    set_in(1, 0, 5, 0, 0, 0, 0, 0, 0); step();
    set_in(0, 0, 0, 0, 0, 1, 0, 0, 0); step();
    set_in(1, 2, 5, 0, 0, 0, 0, 0, 0); #1; check_eq("waw_stall", int'(disp_ready), 0); step();
    set_in(1, 2, 5, 0, 0, 0, 1, 0, 0); step();
    set_in(1, 2, 5, 0, 0, 0, 0, 0, 0); #1; check_eq("waw_free", int'(disp_ready), 1); step();
    set_in(0, 0, 0, 0, 0, 4, 0, 0, 0); step();
    set_in(0, 0, 0, 0, 0, 0, 1, 2, 0); step();

    // WAR: FU0 may not overwrite r7 while FU1 still needs its old value.
    phase = "war";
    set_in(1, 1, 0, 0, 7, 0, 0, 0, 0); step();
    set_in(1, 0, 7, 0, 0, 0, 0, 0, 0); step();
    set_in(0, 0, 0, 0, 0, 1, 0, 0, 0); step();
    set_in(0, 0, 0, 0, 0, 0, 1, 0, 0); #1; check_eq("war_stall", int'(wb_ready), 0); step();
    set_in(0, 0, 0, 0, 0, 2, 1, 0, 0); #1; check_eq("war_grant_cyc", int'(wb_ready), 0); step();
    set_in(0, 0, 0, 0, 0, 0, 1, 0, 0); #1; check_eq("war_free", int'(wb_ready), 1); step();
    set_in(0, 0, 0, 0, 0, 0, 1, 1, 0); step();

    // Bypass: dispatch reading r9 in the cycle its producer retires.
    phase = "bypass";
    set_in(1, 0, 9, 0, 0, 0, 0, 0, 0); step();
    set_in(0, 0, 0, 0, 0, 1, 0, 0, 0); step();
    set_in(1, 1, 10, 9, 0, 0, 1, 0, 0); step();
    check_eq("bypass_rdy", int'(issue_rdy[1]), 1);
    set_in(0, 0, 0, 0, 0, 2, 0, 0, 0); step();
    set_in(0, 0, 0, 0, 0, 0, 1, 1, 0); step();

    // rd=0 never creates a producer.
    phase = "rd0";
    set_in(1, 0, 0, 1, 2, 0, 0, 0, 0); #1; check_eq("rd0_a", int'(disp_ready), 1); step();
    set_in(1, 1, 0, 0, 0, 0, 0, 0, 0); #1; check_eq("rd0_b", int'(disp_ready), 1); step();
    set_in(1, 2, 0, 0, 0, 0, 0, 0, 0); step();
    check_eq("rd0_busy", int'(busy_o), 7);
    check_eq("rd0_rdy", int'(issue_rdy), 7);
    set_in(0, 0, 0, 0, 0, 7, 0, 0, 0); step();
    for (int f = 0; f < NFU; f++) begin
      set_in(0, 0, 0, 0, 0, 0, 1, f, 0); step();
    end

    // Flush with three busy rows and competing traffic.
    phase = "flush";
    set_in(1, 0, 10, 0, 0, 0, 0, 0, 0); step();
    set_in(1, 1, 11, 10, 0, 1, 0, 0, 0); step();
    set_in(1, 2, 12, 0, 0, 0, 0, 0, 0); step();
    check_eq("flush_pre", int'(busy_o), 7);
    set_in(1, 0, 13, 0, 0, 7, 1, 0, 1); step();
    check_eq("flush_busy", int'(busy_o), 0);
    for (int k = 10; k <= 13; k++) begin
      set_in(1, k % NFU, k, 0, 0, 0, 0, 0, 0);
      #1;
      check_eq("flush_rs", int'(disp_ready), 1);
    end
    idle(); step();

    // Asynchronous reset mid-cycle.
    phase = "rst";
    set_in(1, 0, 14, 0, 0, 0, 0, 0, 0); step();
    set_in(1, 1, 15, 14, 0, 1, 0, 0, 0); step();
    set_in(1, 2, 16, 0, 0, 0, 0, 0, 0); step();
    check_eq("rst_pre", int'(busy_o), 7);
    set_in(1, 0, 14, 0, 0, 7, 1, 0, 0);
    #2;
    RST = 1'b1;
    #1;
    model_reset();
    check_eq("rst_busy", int'(busy_o), 0);
    check_eq("rst_issue", int'(issue_rdy), 0);
    check_eq("rst_wb", int'(wb_ready), 0);
    check_eq("rst_disp", int'(disp_ready), 1);
    @(negedge CLK);
    RST = 1'b0;
    set_in(1, 0, 14, 0, 0, 0, 0, 0, 0); step();

    // Random traffic over a small register window to provoke hazards.
    phase = "random";
    for (int c = 0; c < 500; c++) begin
      set_in(bit'($urandom_range(0, 1)), int'($urandom_range(0, 2)), int'($urandom_range(0, 7)),
             int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
             bit'($urandom_range(0, 1)), int'($urandom_range(0, 2)), ($urandom_range(0, 31) == 0));
      step();
    end

    idle();
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
